alu_decoder_seq: RTL and testbench

Second-generation ALU control for the RV32 core. It decodes ALUop, funct3, funct7 and OP5 into a 4-bit ALU control word covering the full RV32I ALU set. It also recognises RV32M ops and sequences an external iterative mul/div datapath with a step counter. Sits between the main control unit and the execute stage. Has a registered valid/ready output so execute can stall it.

---
 rtl/alu_decoder_seq.sv | 157 +++++++++++++++
 tb/tb_alu_decoder_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder_seq.sv
// RV32 ALU control decoder with RV32M recognition and an iterative mul/div step sequencer.
// Optional build macro MD_EARLY_OUT_EN: divide/remainder by zero skips the iteration phase.
module alu_decoder_seq #(
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              op5,
  input  logic              md_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              is_muldiv,
  output logic [2:0]        md_op,
  output logic              md_step,
  output logic              md_first,
  output logic              md_last,
  output logic              illegal
);

  localparam logic [3:0] C_ADD   = 4'b0000;
  localparam logic [3:0] C_SUB   = 4'b0001;
  localparam logic [3:0] C_AND   = 4'b0010;
  localparam logic [3:0] C_OR    = 4'b0011;
  localparam logic [3:0] C_XOR   = 4'b0100;
  localparam logic [3:0] C_SLT   = 4'b0101;
  localparam logic [3:0] C_SLTU  = 4'b0110;
  localparam logic [3:0] C_SLL   = 4'b0111;
  localparam logic [3:0] C_SRL   = 4'b1000;
  localparam logic [3:0] C_SRA   = 4'b1001;
  localparam logic [3:0] C_PASSB = 4'b1010;
  localparam logic [3:0] C_ILL   = 4'b1111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ctrl_q;
  logic [3:0]       ctrl_next;
  logic             is_m;
  logic             is_ill;
  logic             early;
  logic             accept;

  function automatic logic [3:0] decode_ctrl(input logic [1:0] aop, input logic [2:0] f3,
                                             input logic f75, input logic o5);
    logic [3:0] c;
    c = C_ADD;
    case (aop)
      2'b00: c = C_ADD;
      2'b01: c = C_SUB;
      2'b11: c = C_PASSB;
      default: begin
        case (f3)
          3'b000:  c = (o5 & f75) ? C_SUB : C_ADD;
          3'b001:  c = C_SLL;
          3'b010:  c = C_SLT;
          3'b011:  c = C_SLTU;
          3'b100:  c = C_XOR;
          3'b101:  c = f75 ? C_SRA : C_SRL;
          3'b110:  c = C_OR;
          default: c = C_AND;
        endcase
      end
    endcase
    return c;
  endfunction

  always_comb begin
    is_m      = (alu_op == 2'b10) & op5 & funct7_0 & ~funct7_5;
    is_ill    = (alu_op == 2'b10) & op5 & funct7_5 &
                (funct7_0 | ~((funct3 == 3'b000) | (funct3 == 3'b101)));
    ctrl_next = is_ill ? C_ILL : (is_m ? C_ADD : decode_ctrl(alu_op, funct3, funct7_5, op5));
  end

`ifdef MD_EARLY_OUT_EN
  assign early = funct3[2] & md_zero;
`else
  logic unused_md_zero;
  assign unused_md_zero = md_zero;
  assign early = 1'b0;
`endif

  assign in_ready = (state == IDLE) & (~out_valid | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  // Step strobes depend only on state/counter so the datapath sees no input-driven glitches.
  assign md_step  = (state == MD_RUN);
  assign md_first = md_step & (cnt == '0);
  assign md_last  = md_step & (cnt == CNT_LAST);
  assign alu_ctrl = CTRL_W'(ctrl_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      ctrl_q    <= C_ADD;
      is_muldiv <= 1'b0;
      md_op     <= 3'b000;
      illegal   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid & out_ready) out_valid <= 1'b0;
          if (accept) begin
            ctrl_q    <= ctrl_next;
            illegal   <= is_ill;
            is_muldiv <= is_m;
            md_op     <= is_m ? funct3 : 3'b000;
            if (is_m & ~early) begin
              state     <= MD_RUN;
              cnt       <= '0;
              out_valid <= 1'b0;
            end else if (is_m) begin
              state     <= MD_DONE;
              out_valid <= 1'b1;
            end else begin
              out_valid <= 1'b1;
            end
          end
        end
        MD_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state     <= MD_DONE;
            cnt       <= '0;
            out_valid <= 1'b1;
          end
        end
        MD_DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_decoder_seq.sv
// Directed bench for alu_decoder_seq: reference model checked every cycle plus literal expectations.
module tb_alu_decoder_seq;
  localparam int MD_CYCLES = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] alu_op = 2'b00;
  logic [2:0] funct3 = 3'b000;
  logic       funct7_5 = 1'b0;
  logic       funct7_0 = 1'b0;
  logic       op5 = 1'b0;
  logic       md_zero = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready, out_valid, is_muldiv, md_step, md_first, md_last, illegal;
  logic [3:0] alu_ctrl;
  logic [2:0] md_op;

  alu_decoder_seq #(.CTRL_W(4), .MD_CYCLES(MD_CYCLES), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0), .op5(op5),
    .md_zero(md_zero), .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
    .is_muldiv(is_muldiv), .md_op(md_op), .md_step(md_step), .md_first(md_first),
    .md_last(md_last), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: operation table plus a countdown of remaining iterations.
  logic [3:0] base_tbl [8] = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
  int         m_busy = 0;
  bit         m_valid = 0;
  bit         m_mul = 0;
  bit         m_ill = 0;
  logic [3:0] m_ctrl = 4'h0;
  logic [2:0] m_op = 3'b000;

  function automatic void ref_decode(input logic [1:0] aop, input logic [2:0] f3, input logic f75,
                                     input logic f70, input logic o5,
                                     output logic [3:0] c, output bit m, output bit il);
    bit rtype;
    rtype = (aop == 2'd2) && o5;
    m  = rtype && f70 && !f75;
    il = rtype && f75 && (f70 || !(f3 == 3'd0 || f3 == 3'd5));
    if (il) c = 4'hF;
    else if (m || aop == 2'd0) c = 4'h0;
    else if (aop == 2'd1) c = 4'h1;
    else if (aop == 2'd3) c = 4'hA;
    else c = base_tbl[f3] + 4'((f75 && ((f3 == 3'd0 && o5) || f3 == 3'd5)) ? 1 : 0);
  endfunction

  function bit m_ready();
    return !flush && m_busy == 0 && !(m_valid && m_mul) && (!m_valid || out_ready);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_mul = 0; m_ill = 0; m_ctrl = 4'h0; m_op = 3'b000;
    end else if (flush) begin
      m_busy = 0; m_valid = 0;
    end else begin : model_step
      bit acc, m, il, early;
      logic [3:0] c;
      acc = in_valid && m_ready();
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) m_valid = 1;
      end else if (m_valid && out_ready) m_valid = 0;
      if (acc) begin
        ref_decode(alu_op, funct3, funct7_5, funct7_0, op5, c, m, il);
        m_ctrl = c; m_ill = il; m_mul = m; m_op = m ? funct3 : 3'b000;
        early = 0;
`ifdef MD_EARLY_OUT_EN
        early = m && funct3[2] && md_zero;
`endif
        if (m && !early) begin m_busy = MD_CYCLES; m_valid = 0; end
        else m_valid = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, m_valid);
    chk("in_ready", in_ready, m_ready());
    chk("md_step", md_step, m_busy > 0);
    chk("md_first", md_first, m_busy == MD_CYCLES);
    chk("md_last", md_last, m_busy == 1);
    if (m_valid) begin
      chk("alu_ctrl", alu_ctrl, m_ctrl);
      chk("is_muldiv", is_muldiv, m_mul);
      chk("md_op", md_op, m_op);
      chk("illegal", illegal, m_ill);
    end
  end

  task automatic set_op(input logic [1:0] a, input logic [2:0] f3, input logic f75,
                        input logic f70, input logic o5, input logic mz);
    alu_op = a; funct3 = f3; funct7_5 = f75; funct7_0 = f70; op5 = o5; md_zero = mz;
  endtask

  task automatic send(input logic [1:0] a, input logic [2:0] f3, input logic f75,
                      input logic f70, input logic o5, input logic mz);
    bit got;
    got = 0;
    set_op(a, f3, f75, f70, o5, mz);
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (got) begin @(posedge clk); #1; end
    else chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_step"}, {md_step, md_first, md_last}, 0);
    chk({nm, "_ctrl"}, alu_ctrl, 0);
    chk({nm, "_flags"}, {is_muldiv, illegal}, 0);
    chk({nm, "_mdop"}, md_op, 0);
  endtask

  logic [1:0] b2b_aop [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2};
  logic [2:0] b2b_f3  [8] = '{3'd0, 3'd4, 3'd2, 3'd0, 3'd4, 3'd2, 3'd0, 3'd4};
  logic       b2b_o5  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [3:0] b2b_exp [8] = '{4'h0, 4'h4, 4'h5, 4'h0, 4'h4, 4'h5, 4'h0, 4'h4};

  initial begin
    int fk, lk, vk, steps, seen, lasts;
    logic [2:0] op_at_v;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Decode sweep, each result one cycle after accept
    send(2'd2, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0); @(negedge clk);
    chk("lit_sub_v", out_valid, 1); chk("lit_sub", alu_ctrl, 4'b0001);
    send(2'd2, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0); @(negedge clk);
    chk("lit_sra", alu_ctrl, 4'b1001);
    send(2'd2, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0); @(negedge clk);
    chk("lit_ill_ctrl", alu_ctrl, 4'b1111); chk("lit_ill_flag", illegal, 1);
    send(2'd1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0); @(negedge clk);
    chk("lit_branch", alu_ctrl, 4'b0001); chk("lit_branch_ill", illegal, 0);
    send(2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0); @(negedge clk);
    chk("lit_passb", alu_ctrl, 4'b1010);
    send(2'd2, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0); @(negedge clk);
    chk("lit_sltu", alu_ctrl, 4'b0110);
    send(2'd2, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0); @(negedge clk);
    chk("lit_both7", alu_ctrl, 4'b1111);
    send(2'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0); @(negedge clk);
    chk("lit_addi", alu_ctrl, 4'b0000);
    send(2'd2, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0); @(negedge clk);
    chk("lit_srli", alu_ctrl, 4'b1000);
    @(posedge clk); #1;

    // Back-to-back ops with no bubbles
    for (int i = 0; i < 8; i++) begin
      set_op(b2b_aop[i], b2b_f3[i], 1'b0, 1'b0, b2b_o5[i], 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_ready", in_ready, 1);
      if (i > 0) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_order", alu_ctrl, b2b_exp[i-1]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid_last", out_valid, 1); chk("b2b_order_last", alu_ctrl, b2b_exp[7]);
    @(posedge clk); #1;

    // MUL timing
    send(2'd2, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    fk = -1; lk = -1; vk = -1; steps = 0; op_at_v = 3'b111;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (md_first && fk < 0) fk = k;
      if (md_last && lk < 0) lk = k;
      if (out_valid && vk < 0) begin vk = k; op_at_v = md_op; end
      if (md_step) steps++;
      if (k <= 33) chk("mul_in_ready", in_ready, 0);
    end
    chk("mul_first", fk, 1); chk("mul_last", lk, 32); chk("mul_valid", vk, 33);
    chk("mul_steps", steps, 32); chk("mul_mdop", op_at_v, 3'b000);
    @(posedge clk); #1;

    // Backpressure holds the result
    out_ready = 1'b0;
    send(2'd2, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1); chk("bp_ctrl", alu_ctrl, 4'b0011);
      chk("bp_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush at step 10 of a DIV, with an op offered during the flush cycle
    send(2'd2, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    flush = 1'b1;
    set_op(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("flush_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid || md_step) seen++;
    end
    chk("flush_quiet", seen, 0);
    @(posedge clk); #1;

    // DIVU by zero
    send(2'd2, 3'd5, 1'b0, 1'b1, 1'b1, 1'b1);
    vk = -1; steps = 0;
    for (int k = 1; k <= 40 && vk < 0; k++) begin
      @(negedge clk);
      if (md_step) steps++;
      if (out_valid) vk = k;
    end
`ifdef MD_EARLY_OUT_EN
    chk("divz_latency", vk, 1); chk("divz_steps", steps, 0);
`else
    chk("divz_latency", vk, 33); chk("divz_steps", steps, 32);
`endif
    chk("divz_mdop", md_op, 3'b101);
    md_zero = 1'b0;
    @(posedge clk); #1;

    // Reset in the middle of an iteration
    send(2'd2, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", in_ready, 1);
    lasts = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (md_last || out_valid) lasts++;
    end
    chk("midrst_no_last", lasts, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
